// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the sequential non-restoring divider:
// FSM encoding, add/sub mode codes and counter sizing.
package arith_pkg;

    localparam int DEF_N = 8;
    localparam int CNT_W = $clog2(DEF_N);

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_ITER = 2'd1;
    localparam state_t S_FIX  = 2'd2;
    localparam state_t S_DONE = 2'd3;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Iteration counter width for an n-bit divider, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nrdiv_seq_if.sv
// Start/done handshake and operand/result bundle of the sequential divider.
// Handshake: start is sampled only while busy=0; done pulses for one cycle and results hold until the next accepted start.
interface nrdiv_seq_if
    import arith_pkg::*;
#(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    state_t       dbg_state;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, dbg_state
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, dbg_state
    );
endinterface

// File: rtl/nrdiv_addsub.sv
// Combinational W-bit adder/subtractor: y = a + (b XOR {W{m}}) + m, so m=1 subtracts.
module nrdiv_addsub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         m,
    output logic [W-1:0] y
);
    assign y = a + (b ^ {W{m}}) + {{(W-1){1'b0}}, m};
endmodule

// File: rtl/nrdiv_seq.sv
// Sequential non-restoring divider, one add/sub step per clock.
// Define NRDIV_SIGNED_EN for two's-complement operands (truncating division).
module nrdiv_seq
    import arith_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         rst_n,
    nrdiv_seq_if.slave   bus
);
    localparam int CW = cnt_width(N);

    state_t        state;
    logic [N:0]    p;
    logic [N-1:0]  q;
    logic [N-1:0]  d;
    logic [CW-1:0] count;
    logic          zero_div;
    logic          busy_r;
    logic          done_r;
    logic [N-1:0]  quo_r;
    logic [N-1:0]  rem_r;
    logic          dbz_r;

    logic [N:0]    p_shift;
    logic [N:0]    d_ext;
    logic [N:0]    add_a;
    logic [N:0]    sum;
    logic [N:0]    p_fix;
    logic          mode;
    logic [N-1:0]  dvd_mag;
    logic [N-1:0]  dvs_mag;
    logic [N-1:0]  quo_fix;
    logic [N-1:0]  rem_fix;

`ifdef NRDIV_SIGNED_EN
    logic sign_n;
    logic sign_d;

    assign dvd_mag = bus.dividend[N-1] ? ('0 - bus.dividend) : bus.dividend;
    assign dvs_mag = bus.divisor[N-1]  ? ('0 - bus.divisor)  : bus.divisor;
    assign quo_fix = (sign_n ^ sign_d) ? ('0 - q) : q;
    assign rem_fix = sign_n ? ('0 - p_fix[N-1:0]) : p_fix[N-1:0];
`else
    assign dvd_mag = bus.dividend;
    assign dvs_mag = bus.divisor;
    assign quo_fix = q;
    assign rem_fix = p_fix[N-1:0];
`endif

    // The single adder serves both the per-bit step (ITER) and the final
    // remainder correction (FIX).
    always_comb begin
        p_shift = {p[N-1:0], q[N-1]};
        d_ext   = {1'b0, d};
        add_a   = p_shift;
        mode    = p[N] ? MODE_ADD : MODE_SUB;
        if (state == S_FIX) begin
            add_a = p;
            mode  = MODE_ADD;
        end
    end

    nrdiv_addsub #(.W(N + 1)) u_addsub (
        .a (add_a),
        .b (d_ext),
        .m (mode),
        .y (sum)
    );

    assign p_fix = p[N] ? sum : p;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            p        <= '0;
            q        <= '0;
            d        <= '0;
            count    <= '0;
            zero_div <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            quo_r    <= '0;
            rem_r    <= '0;
            dbz_r    <= 1'b0;
`ifdef NRDIV_SIGNED_EN
            sign_n   <= 1'b0;
            sign_d   <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A start coinciding with the done pulse is not taken.
                    if (bus.start && !done_r) begin
                        busy_r <= 1'b1;
                        p      <= '0;
                        d      <= dvs_mag;
                        count  <= CW'(N - 1);
`ifdef NRDIV_SIGNED_EN
                        sign_n <= bus.dividend[N-1];
                        sign_d <= bus.divisor[N-1];
`endif
                        // Divide-by-zero passes through FIX untouched so its
                        // latency is two cycles; q keeps the raw dividend.
                        if (bus.divisor == '0) begin
                            zero_div <= 1'b1;
                            q        <= bus.dividend;
                            state    <= S_FIX;
                        end else begin
                            zero_div <= 1'b0;
                            q        <= dvd_mag;
                            state    <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    p <= sum;
                    q <= {q[N-2:0], ~sum[N]};
                    if (count == '0) state <= S_FIX;
                    else             count <= count - 1'b1;
                end
                S_FIX: begin
                    if (!zero_div) begin
                        p     <= p_fix;
                        quo_r <= quo_fix;
                        rem_r <= rem_fix;
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    dbz_r  <= zero_div;
                    if (zero_div) begin
                        quo_r <= '1;
                        rem_r <= q;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.dbg_state   = state;

endmodule
